// File: rtl/seg7_pkg.sv
// Shared constants, decode table and FSM state type for the 8-digit
// multiplexed 7-segment display driver.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF = 8'hFF;

  // Active-low {g,f,e,d,c,b,a} patterns; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG7_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {ST_GUARD, ST_ON} state_e;

  function automatic logic [7:0] anode_sel(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern (no decimal point).
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = SEG7_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_demux.sv
// Time-division driver for an 8-digit common-anode display: shadow registers,
// guard/on scan FSM and registered active-low anode/segment outputs.
module seg7_scan_demux
  import seg7_pkg::*;
#(
  parameter int ON_CYC    = 50000,
  parameter int GUARD_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        update,
  input  logic [31:0] hex_data,
  input  logic [7:0]  point,
  input  logic [7:0]  blank,
  output logic [7:0]  AN,
  output logic [7:0]  SEGMENT
);

  localparam int MAX_CYC = (ON_CYC > GUARD_CYC) ? ON_CYC : GUARD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);

  logic [31:0]      sh_hex_q, sh_hex_d;
  logic [7:0]       sh_pt_q, sh_pt_d;
  logic [7:0]       sh_blk_q, sh_blk_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       lit_an_q, lit_an_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       segment_q, segment_d;
  logic [6:0]       dec_seg;

  hex_to_seg7 u_dec (
    .nibble (sh_hex_q[{idx_q, 2'b00} +: 4]),
    .seg_n  (dec_seg)
  );

  always_comb begin
    sh_hex_d  = sh_hex_q;
    sh_pt_d   = sh_pt_q;
    sh_blk_d  = sh_blk_q;
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    seg_d     = seg_q;
    lit_an_d  = lit_an_q;
    an_d      = AN_OFF;
    segment_d = SEG_BLANK;

    if (update) begin
      sh_hex_d = hex_data;
      sh_pt_d  = point;
      sh_blk_d = blank;
    end

    // Pattern and anode are frozen on entry to ON so a lit digit never changes.
    case (state_q)
      ST_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d  = ST_ON;
          cnt_d    = '0;
          seg_d    = {~sh_pt_q[idx_q], dec_seg};
          lit_an_d = sh_blk_q[idx_q] ? AN_OFF : anode_sel(idx_q);
        end
      end
      ST_ON: begin
        an_d      = lit_an_q;
        segment_d = seg_q;
        if (cnt_q == ON_LAST) begin
          state_d = ST_GUARD;
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_GUARD;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_hex_q  <= '0;
      sh_pt_q   <= '0;
      sh_blk_q  <= '0;
      state_q   <= ST_GUARD;
      cnt_q     <= '0;
      idx_q     <= '0;
      an_q      <= AN_OFF;
      segment_q <= SEG_BLANK;
    end else begin
      sh_hex_q  <= sh_hex_d;
      sh_pt_q   <= sh_pt_d;
      sh_blk_q  <= sh_blk_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      segment_q <= segment_d;
    end
  end

  // Latched digit data is only consumed in ON, which is always entered via a latch.
  always_ff @(posedge clk) begin
    seg_q    <= seg_d;
    lit_an_q <= lit_an_d;
  end

  assign AN      = an_q;
  assign SEGMENT = segment_q;

endmodule

// File: tb/tb_seg7_scan_demux.sv
// Self-checking bench for seg7_scan_demux: vector table, hand-written corner
// sequences and a slot scoreboard fed by the stimulus.
module tb_seg7_scan_demux;

  localparam int ON    = 4;
  localparam int GUARD = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        update = 1'b0;
  logic [31:0] hex_data = '0;
  logic [7:0]  point = '0;
  logic [7:0]  blank = '0;
  logic [7:0]  AN;
  logic [7:0]  SEGMENT;

  seg7_scan_demux #(.ON_CYC(ON), .GUARD_CYC(GUARD)) dut (
    .clk      (clk),
    .rst      (rst),
    .update   (update),
    .hex_data (hex_data),
    .point    (point),
    .blank    (blank),
    .AN       (AN),
    .SEGMENT  (SEGMENT)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] an;
    logic [7:0] seg;
  } slot_t;

  typedef struct packed {
    logic [31:0]     hex;
    logic [7:0]      pt;
    logic [7:0]      blk;
    logic [7:0][7:0] seg;
  } vec_t;

  slot_t      exp_q[$];
  vec_t       vecs [3];
  logic [6:0] dec_tab [16];
  int         n_chk = 0;
  int         n_err = 0;
  int         edge_n = 0;

  bit         in_slot = 0;
  bit         chk_slot = 0;
  bit         stable = 0;
  int         len = 0;
  int         gap = -1;
  logic [7:0] cur_an, cur_seg;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] exp_an(input int k, input logic [7:0] blk);
    return blk[k] ? 8'hFF : ~(8'h01 << k);
  endfunction

  task automatic push_exp(input logic [7:0] an, input logic [7:0] seg);
    slot_t s;
    s.an  = an;
    s.seg = seg;
    exp_q.push_back(s);
  endtask

  task automatic push_slot(input int k, input logic [31:0] hex, input logic [7:0] pt,
                           input logic [7:0] blk);
    push_exp(exp_an(k, blk), {~pt[k], dec_tab[hex[4*k +: 4]]});
  endtask

  task automatic monitor_step();
    slot_t e;
    check_int("anode_overlap", ($countones(~AN) > 1) ? 1 : 0, 0);
    if (rst) begin
      in_slot  = 0;
      chk_slot = 0;
      gap      = -1;
    end else if (SEGMENT != 8'hFF) begin
      if (!in_slot) begin
        in_slot  = 1;
        len      = 1;
        stable   = 1;
        cur_an   = AN;
        cur_seg  = SEGMENT;
        chk_slot = 0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk_slot = 1;
          check8("slot_an", AN, e.an);
          check8("slot_seg", SEGMENT, e.seg);
          if (gap >= 0) check_int("guard_gap", gap, GUARD);
        end
        gap = 0;
      end else begin
        len++;
        if (AN !== cur_an || SEGMENT !== cur_seg) stable = 0;
      end
    end else if (in_slot) begin
      in_slot = 0;
      if (chk_slot) begin
        check_int("slot_len", len, ON);
        check_int("slot_stable", int'(stable), 1);
      end
      gap = 1;
    end else if (gap >= 0) begin
      gap++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  // Leaves the bench #1 after the last reset edge with rst low and edge_n=0.
  task automatic do_reset(input logic upd, input logic [31:0] hex, input logic [7:0] pt,
                          input logic [7:0] blk);
    rst      = 1'b1;
    update   = upd;
    hex_data = hex;
    point    = pt;
    blank    = blk;
    repeat (3) tick();
    rst    = 1'b0;
    update = 1'b0;
    edge_n = 0;
    exp_q.delete();
  endtask

  task automatic pulse_update(input int at_edge, input logic [31:0] hex, input logic [7:0] pt,
                              input logic [7:0] blk);
    while (edge_n < at_edge - 1) tick();
    hex_data = hex;
    point    = pt;
    blank    = blk;
    update   = 1'b1;
    tick();
    update   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    check_int("queue_drained", exp_q.size(), 0);
    repeat (8) tick();
  endtask

  initial begin
    logic [31:0] cur_hex, new_hex;
    logic [7:0]  cur_pt, cur_blk, new_pt, new_blk;
    logic        upd;
    int          n;

    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = {32'h76543210, 8'h00, 8'h00,
               {8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0}};
    vecs[1] = {32'hFEDCBA98, 8'h01, 8'h80,
               {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h00}};
    vecs[2] = {32'h0F1E2D3C, 8'hAA, 8'h05,
               {8'h40, 8'h8E, 8'h79, 8'h86, 8'h24, 8'hA1, 8'h30, 8'hC6}};

    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset wins over a simultaneous update: first frame must be all zeros.
    do_reset(1'b1, 32'hFFFFFFFF, 8'hFF, 8'hFF);
    check8("reset_an", AN, 8'hFF);
    check8("reset_seg", SEGMENT, 8'hFF);
    for (int k = 0; k < 8; k++) push_exp(~(8'h01 << k), 8'hC0);
    drain();

    // Table vectors: update lands mid-ON of digit 0, so digit 0 of frame 1 keeps C0.
    for (int i = 0; i < 3; i++) begin
      do_reset(1'b0, 32'h0, 8'h00, 8'h00);
      push_exp(8'hFE, 8'hC0);
      for (int k = 1; k < 8; k++) push_exp(exp_an(k, vecs[i].blk), vecs[i].seg[k]);
      for (int k = 0; k < 8; k++) push_exp(exp_an(k, vecs[i].blk), vecs[i].seg[k]);
      pulse_update(3, vecs[i].hex, vecs[i].pt, vecs[i].blk);
      drain();
    end

    // Reset asserted mid-ON of digit 5.
    n = 0;
    while (AN !== 8'hDF && n < 100) begin
      @(negedge clk);
      n++;
    end
    check8("digit5_seen", AN, 8'hDF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check8("mid_on_reset_an", AN, 8'hFF);
    check8("mid_on_reset_seg", SEGMENT, 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    edge_n = 0;
    tick();
    check8("post_reset_edge1_an", AN, 8'hFF);
    tick();
    check8("post_reset_edge2_an", AN, 8'hFE);
    check8("post_reset_edge2_seg", SEGMENT, 8'hC0);
    repeat (50) tick();

    // Update coinciding with digit 3's GUARD->ON edge (edge 16 after reset).
    do_reset(1'b0, 32'h0, 8'h00, 8'h00);
    push_slot(0, 32'h0, 8'h00, 8'h00);
    for (int k = 1; k < 4; k++) push_slot(k, 32'h89ABCDEF, 8'h00, 8'h00);
    for (int k = 4; k < 8; k++) push_slot(k, 32'h01234567, 8'h10, 8'h00);
    for (int k = 0; k < 8; k++) push_slot(k, 32'h01234567, 8'h10, 8'h00);
    pulse_update(3, 32'h89ABCDEF, 8'h00, 8'h00);
    pulse_update(16, 32'h01234567, 8'h10, 8'h00);
    drain();

    // Ten frames of random updates against a shadow model.
    do_reset(1'b0, 32'h0, 8'h00, 8'h00);
    cur_hex = '0;
    cur_pt  = '0;
    cur_blk = '0;
    for (int e = 1; e <= 400; e++) begin
      if ((e - 1) % 5 == 0) push_slot(((e - 1) / 5) % 8, cur_hex, cur_pt, cur_blk);
      upd     = ($urandom_range(0, 5) == 0);
      new_hex = $urandom;
      new_pt  = 8'($urandom);
      new_blk = 8'($urandom & $urandom & $urandom);
      hex_data = new_hex;
      point    = new_pt;
      blank    = new_blk;
      update   = upd;
      tick();
      update   = 1'b0;
      if (upd) begin
        cur_hex = new_hex;
        cur_pt  = new_pt;
        cur_blk = new_blk;
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_demux.md
# seg7_scan_demux

Time-division driver for the board's 8-digit common-anode 7-segment display. It accepts a 32-bit hex word plus per-digit decimal-point and blank masks, holds them in shadow registers, and demultiplexes them onto one shared segment bus with a rotating active-low anode select. It is the output-side counterpart of the 2:1 data-select path in the display datapath, and sits between the display-data mux and the board pins.

## Interface
- `ON_CYC`, default 50000: cycles each digit is lit; legal range ≥1.
- `GUARD_CYC`, default 500: anti-ghosting dead time between digits, all anodes off; legal range ≥1.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `update`  in  1  single-cycle strobe that loads the shadow registers.
- `hex_data`  in  32  nibble k (`[4k+3:4k]`) is the value for digit k.
- `point`  in  8  bit k=1 lights the decimal point of digit k.
- `blank`  in  8  bit k=1 blanks digit k entirely; its anode stays off.
- `AN`  out  8  anode select, active-low, one-hot-low or all-high.
- `SEGMENT`  out  8  `{dp,g,f,e,d,c,b,a}`, active-low.

## Operation
- Shadow registers `sh_hex`, `sh_pt` and `sh_blk` load from their inputs on any cycle with `update`=1. Otherwise they hold.
- Digit index `idx` (3 bits) wraps 7→0.
- FSM:
  - GUARD: `AN`=8'hFF and `SEGMENT`=8'hFF; counts GUARD_CYC cycles.
  - ON: `AN`=~(1<<idx), or 8'hFF if `sh_blk[idx]`=1. `SEGMENT` is the latched pattern. Counts ON_CYC cycles.
  - On the GUARD→ON transition, the pattern `{~sh_pt[idx], hex2seg(sh_hex[4idx+3:4idx])}` is latched into `seg_q`.
  - On the ON→GUARD transition, `idx` increments.
- A digit's pattern never changes while it is lit. When `update` coincides with the GUARD→ON edge, the old shadow value is latched for that digit. The new data appears from the next digit onward.
- A blanked digit still consumes its full ON slot with `AN`=8'hFF. `SEGMENT` still carries the pattern.
- Decode table (active-low, 7 bits without dp):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - Hex values; with dp off these become C0, F9, … 8E.
- Synchronous `rst` overrides all activity in the cycle it is sampled, including `update`.

## Timing
- All outputs are registered.
- Reset values: `AN`=8'hFF, `SEGMENT`=8'hFF, state=GUARD, counter=0, `idx`=0, shadows=0.
- After `rst` deasserts, the first GUARD lasts GUARD_CYC cycles. Digit 0 is lit starting at the (GUARD_CYC+1)-th clock edge.
- Period per digit is GUARD_CYC+ON_CYC cycles; a full frame is 8×(GUARD_CYC+ON_CYC).
- The shadow update takes effect 1 cycle after the `update` edge. It is visible on the next GUARD→ON transition.
- Counter width is `$clog2(max(ON_CYC,GUARD_CYC))`, at least 1 bit. It clears to 0 on every state change and never overflows.
- Anode overlap is forbidden: no cycle has two `AN` bits low, including across reset.

## Structure
- Shared package `seg7_pkg` holds:
  - `NUM_DIGITS`=8;
  - `SEG_BLANK`=8'hFF;
  - the 16-entry active-low pattern constant array;
  - the FSM state enum `{ST_GUARD, ST_ON}`.
- Sub-module `hex_to_seg7`: purely combinational, 4-bit in, 7-bit active-low out, indexing the package array. It is instantiated once on the selected nibble.
- The top holds the shadow registers, FSM, counter, `idx`, and output registers.

## Test plan
Benches use ON_CYC=4 and GUARD_CYC=1.
- **Reset:** hold `rst` for 3 cycles mid-ON of digit 5 → the next cycle has `AN`=FF and `SEGMENT`=FF. Digit 0 lights 2 edges after `rst` drops, showing C0 (shadow=0).
- **Full scan:** `update` with `hex_data`=32'h76543210, `point`=0, `blank`=0. Expected:
  - digit k is lit for exactly 4 cycles with `AN`=~(1<<k);
  - `SEGMENT` follows C0, F9, A4, B0, 99, 92, 82, F8;
  - exactly 1 all-FF cycle separates consecutive digits;
  - digit 7 wraps back to 0.
- **Point and blank:** `hex_data`=32'hFEDCBA98, `point`=8'h01, `blank`=8'h80. Expected:
  - digit 0 shows `SEGMENT`=00 (8 with dp);
  - digits 1–6 show 90, 88, 83, C6, A1, 86;
  - digit 7 slot has `AN`=FF for 4 cycles.
- **Update collision:** assert `update` with new data on the GUARD→ON edge of digit 3 → digit 3 shows the old nibble, and digit 4 shows the new nibble. Separately, `update` mid-ON leaves the lit `SEGMENT` unchanged.
- **Reset beats update:** `rst` and `update` asserted together → shadows stay 0, and the first frame shows C0 on all digits.
- **Overlap assertion:** over 10 frames with random `update` and random data, `$countones(~AN)` ≤ 1 every cycle, and every nibble matches the 16-entry table.
